// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment display path.
//   - SEG_TABLE : 16-entry hex-to-segment table, active-low {g,f,e,d,c,b,a}
//   - ANODE_OFF : all eight digit selects inactive (active-low)
//   - SEG_OFF   : all seven segments dark (active-low)
//   - scan_state_t : scan FSM encoding (BLANK / SHOW)
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [7:0] ANODE_OFF = 8'hFF;
    localparam logic [6:0] SEG_OFF   = 7'h7F;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// -----------------------------------------------------------------------------
// seg7_hex_decode
// Purely combinational nibble -> active-low seven-segment pattern.
// Ports:
//   nibble  in  4  hex digit to show
//   seg     out 7  active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Scans a 32-bit hex value onto an 8-digit multiplexed seven-segment display.
// Each digit slot lasts REFRESH_DIV cycles; the first BLANK_CYC cycles of a
// slot keep every anode off to suppress ghosting. The displayed value is
// double-buffered and only changes when the scan wraps from digit 7 to 0.
// Parameters:
//   REFRESH_DIV  clk cycles per digit slot (>= 4)
//   BLANK_CYC    blank cycles at the start of a slot (< REFRESH_DIV-1)
// Ports:
//   clk          in  1   system clock
//   reset        in  1   asynchronous, active-high reset
//   value        in  32  value to show; nibble k on digit k (digit 0 rightmost)
//   load         in  1   one-cycle strobe capturing value
//   digit_en     in  8   per-digit enable (0 keeps that anode off)
//   anode        out 8   active-low digit select, registered
//   cathode      out 7   active-low segments {g,f,e,d,c,b,a}, registered
//   frame_start  out 1   one-cycle pulse as the scan wraps to digit 0
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value,
    input  logic        load,
    input  logic [7:0]  digit_en,
    output logic [7:0]  anode,
    output logic [6:0]  cathode,
    output logic        frame_start
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_LAST = DIV_W'(BLANK_CYC - 1);

    scan_state_t      state, state_next;
    logic [DIV_W-1:0] div, div_next;
    logic [2:0]       idx, idx_next;
    logic             slot_end;
    logic             wrap;

    logic [31:0]      pending;
    logic             pend_flag;
    logic [31:0]      display;

    logic [3:0]       cur_nibble;
    logic [6:0]       cur_seg;
    logic [7:0]       lit_mask;

    assign slot_end = (div == DIV_LAST);

    // -------------------------------------------------------------------------
    // Scan FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= BLANK;
            div   <= '0;
            idx   <= '0;
        end else begin
            state <= state_next;
            div   <= div_next;
            idx   <= idx_next;
        end
    end

    // -------------------------------------------------------------------------
    // Scan FSM: next state, divider and digit advance
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        wrap       = 1'b0;
        div_next   = slot_end ? '0 : div + DIV_W'(1);

        case (state)
            BLANK: begin
                if (div == BLANK_LAST) begin
                    state_next = SHOW;
                end
            end
            SHOW: begin
                // BLANK_CYC < REFRESH_DIV-1 guarantees slot_end is only ever
                // seen in SHOW, so the digit advances exactly once per slot.
                if (slot_end) begin
                    state_next = BLANK;
                    idx_next   = idx + 3'd1;
                    wrap       = (idx == 3'd7);
                end
            end
            default: begin
                state_next = BLANK;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Double buffer: loads collect in pending and move to display on the wrap.
    // A load on the wrap cycle itself bypasses pending and lands directly.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending   <= '0;
            pend_flag <= 1'b0;
            display   <= '0;
        end else begin
            if (load) begin
                pending <= value;
            end

            if (wrap) begin
                pend_flag <= 1'b0;
                if (load) begin
                    display <= value;
                end else if (pend_flag) begin
                    display <= pending;
                end
            end else if (load) begin
                pend_flag <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs, one cycle behind the scan state.
    // -------------------------------------------------------------------------
    assign cur_nibble = display[{idx, 2'b00} +: 4];
    assign lit_mask   = digit_en & (8'b1 << idx);

    seg7_hex_decode u_hex_decode (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anode       <= ANODE_OFF;
            cathode     <= SEG_OFF;
            frame_start <= 1'b0;
        end else begin
            frame_start <= wrap;
            if (state == SHOW) begin
                anode   <= ~lit_mask;
                cathode <= cur_seg;
            end else begin
                anode   <= ANODE_OFF;
                cathode <= SEG_OFF;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Directed self-checking bench for seg7_scan_driver with REFRESH_DIV=8 and
// BLANK_CYC=2. Frames are 64 cycles long. Timing is referenced to the cycle on
// which frame_start is high (t=0): slot k is blank at t=8k+1..8k+2 and lit at
// t=8k+3..8k+8, and the next frame_start arrives at t=64.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] value;
    logic        load;
    logic [7:0]  digit_en;
    logic [7:0]  anode;
    logic [6:0]  cathode;
    logic        frame_start;

    int n_cmp = 0;
    int n_bad = 0;

    // Hand-written active-low segment patterns {g,f,e,d,c,b,a}.
    logic [6:0] seg_ref [16];

    seg7_scan_driver #(
        .REFRESH_DIV (8),
        .BLANK_CYC   (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .value       (value),
        .load        (load),
        .digit_en    (digit_en),
        .anode       (anode),
        .cathode     (cathode),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one full frame starting from a frame_start cycle, checking every
    // cycle. Optional loads are driven at sample times la / lb (-1 = none).
    task automatic run_frame(input int fr, input logic [31:0] shown, input logic [7:0] en,
                             input int la, input logic [31:0] va,
                             input int lb, input logic [31:0] vb);
        for (int t = 1; t <= 64; t++) begin
            int k;
            int p;
            logic [7:0] exp_an;
            logic [6:0] exp_ca;
            step();
            load = 1'b0;
            k = (t - 1) / 8;
            p = (t - 1) % 8;
            if (p < 2) begin
                exp_an = 8'hFF;
                exp_ca = 7'h7F;
            end else begin
                exp_an = en[k] ? ~(8'h01 << k) : 8'hFF;
                exp_ca = seg_ref[shown[4*k +: 4]];
            end
            check($sformatf("f%0d_t%0d_anode", fr, t), 32'(anode), 32'(exp_an));
            check($sformatf("f%0d_t%0d_cathode", fr, t), 32'(cathode), 32'(exp_ca));
            check($sformatf("f%0d_t%0d_frame_start", fr, t), 32'(frame_start), 32'(t == 64));
            if (t == la) begin
                value = va;
                load  = 1'b1;
            end
            if (t == lb) begin
                value = vb;
                load  = 1'b1;
            end
        end
    endtask

    initial begin
        seg_ref[0]  = 7'b1000000; seg_ref[1]  = 7'b1111001;
        seg_ref[2]  = 7'b0100100; seg_ref[3]  = 7'b0110000;
        seg_ref[4]  = 7'b0011001; seg_ref[5]  = 7'b0010010;
        seg_ref[6]  = 7'b0000010; seg_ref[7]  = 7'b1111000;
        seg_ref[8]  = 7'b0000000; seg_ref[9]  = 7'b0010000;
        seg_ref[10] = 7'b0001000; seg_ref[11] = 7'b0000011;
        seg_ref[12] = 7'b1000110; seg_ref[13] = 7'b0100001;
        seg_ref[14] = 7'b0000110; seg_ref[15] = 7'b0001110;

        reset    = 1'b1;
        value    = 32'h0;
        load     = 1'b0;
        digit_en = 8'hFF;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_anode", 32'(anode), 32'hFF);
        check("rst_cathode", 32'(cathode), 32'h7F);
        check("rst_frame_start", 32'(frame_start), 32'h0);

        // Release: first lit digit (0 from the cleared display) at cycle 3.
        @(negedge clk);
        reset = 1'b0;
        step();
        check("rel_c1_anode", 32'(anode), 32'hFF);
        check("rel_c1_cathode", 32'(cathode), 32'h7F);
        step();
        check("rel_c2_anode", 32'(anode), 32'hFF);
        step();
        check("rel_c3_anode", 32'(anode), 32'hFE);
        check("rel_c3_cathode", 32'(cathode), 32'(7'b1000000));

        // Load the scan-order pattern; it is held until the first wrap.
        value = 32'h76543210;
        load  = 1'b1;
        begin
            int guard = 0;
            step();
            load = 1'b0;
            while (frame_start !== 1'b1 && guard < 200) begin
                step();
                guard++;
            end
            check("first_frame_start_seen", 32'(frame_start), 32'h1);
        end

        // Frame 1: 76543210 in scan order; a mid-frame load of FFFFFFFF must
        // not disturb the remaining digits of this frame.
        run_frame(1, 32'h76543210, 8'hFF, 20, 32'hFFFFFFFF, -1, 32'h0);

        // Frame 2: all F. Two loads in one frame, last one wins.
        run_frame(2, 32'hFFFFFFFF, 8'hFF, 10, 32'h11111111, 30, 32'h22222222);

        // Frame 3: all 2. Load AAAAAAAA on the wrap cycle itself.
        run_frame(3, 32'h22222222, 8'hFF, 63, 32'hAAAAAAAA, -1, 32'h0);

        // Frame 4: A shown immediately after the coincident load.
        run_frame(4, 32'hAAAAAAAA, 8'hFF, -1, 32'h0, -1, 32'h0);

        // Frame 5: only digits 0 and 2 enabled; timing unchanged.
        digit_en = 8'b0000_0101;
        run_frame(5, 32'hAAAAAAAA, 8'b0000_0101, -1, 32'h0, -1, 32'h0);

        // Mid-frame reset: outputs blank with no clock edge, display cleared.
        repeat (20) step();
        check("mid_lit_anode", 32'(anode), 32'hFB);
        check("mid_lit_cathode", 32'(cathode), 32'(7'b0001000));
        reset = 1'b1;
        #1;
        check("async_rst_anode", 32'(anode), 32'hFF);
        check("async_rst_cathode", 32'(cathode), 32'h7F);
        check("async_rst_frame_start", 32'(frame_start), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step();
        check("rerel_c1_anode", 32'(anode), 32'hFF);
        step();
        check("rerel_c2_anode", 32'(anode), 32'hFF);
        step();
        check("rerel_c3_anode", 32'(anode), 32'hFE);
        check("rerel_c3_cathode", 32'(cathode), 32'(7'b1000000));
        check("rerel_c3_frame_start", 32'(frame_start), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream display stage for the counter top level. Takes a 32-bit count value (8 hex nibbles) and drives the board's 8-digit multiplexed seven-segment display through the anode[7:0] and cathode[6:0] pins.
- Scans one digit at a time at a fixed refresh rate, with a short all-off blanking gap between digits to suppress ghosting.
- Double-buffers the displayed value so that a new value only takes effect at a frame boundary.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz); minimum 4.
- BLANK_CYC, 50, cycles with all anodes off at the start of each digit slot; must be less than REFRESH_DIV-1.

Ports:
- clk  in  1  system clock, single clock domain.
- reset  in  1  asynchronous, active-high reset.
- value  in  32  hex value to display; nibble k is shown on digit k (digit 0 is the rightmost).
- load  in  1  one-cycle strobe that captures value.
- digit_en  in  8  per-digit enable; 0 keeps that anode off for the whole slot.
- anode  out  8  active-low digit select, registered.
- cathode  out  7  active-low segments {g,f,e,d,c,b,a}, registered.
- frame_start  out  1  one-cycle pulse when the scan wraps to digit 0.

Behaviour:
- Reset (asynchronous, active-high), all of the following apply immediately:
  - anode=8'hFF, cathode=7'h7F, frame_start=0.
  - Digit index=0, divider=0, state=BLANK.
  - pending register=0, pending flag=0, display register=0.
- Divider:
  - div counts 0..REFRESH_DIV-1 and wraps.
  - slot_end is asserted when div==REFRESH_DIV-1.
- State machine, two states:
  - BLANK: anode driven to 8'hFF. When div==BLANK_CYC-1, go to SHOW.
  - SHOW: anode[idx]=~digit_en[idx]; all other anode bits are 1. cathode=decode(display[4*idx+3:4*idx]).
  - On slot_end in SHOW: go to BLANK, div resets to 0 through its wrap, and idx advances. idx wraps 7→0.
- frame_start pulses on the cycle idx transitions 7→0.
- Output latency:
  - anode/cathode are registered and reflect state/idx one cycle after the transition.
  - The first lit digit appears BLANK_CYC+1 cycles after reset release.
- Load / double-buffer:
  - load=1 captures value into pending and sets the pending flag.
  - On the 7→0 wrap with the flag set, display←pending and the flag clears.
  - A load with no following wrap is held until the wrap.
  - A load coinciding with the wrap loads value straight into display and clears the flag.
  - Multiple loads within one frame: the last one wins.
- Decode (active low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Cathode during BLANK holds 7'h7F.
- digit_en changes take effect on the next registered output update; they do not alter scan timing.
- Reset asserted mid-frame:
  - Outputs go blank immediately and the display value is lost.
  - After release, scanning restarts at digit 0 in BLANK.

Decomposition:
- Shared package seg7_pkg holds:
  - The 16-entry hex-to-segment constant table.
  - The ANODE_OFF (8'hFF) and SEG_OFF (7'h7F) constants.
  - The state encoding (BLANK=1'b0, SHOW=1'b1).
- One natural sub-module: seg7_hex_decode (purely combinational nibble→segments). It is reused by other display paths.
- The scan FSM, divider and double buffer stay in seg7_scan_driver.

Test Plan:
- All tests use REFRESH_DIV=8, BLANK_CYC=2.
- Reset: assert reset mid-scan → anode=FF and cathode=7F in the same cycle with no clock edge. Release → first anode=FE appears at cycle 3.
- Scan order: load value=32'h76543210 with digit_en=FF, let one frame pass → anode walks FE,FD,FB,...,7F. Each digit shows decode(k), e.g. digit 3 shows 0110000. frame_start pulses once every 64 cycles.
- Blanking: check that every slot begins with exactly 2 cycles of anode=FF and cathode=7F, followed by 6 lit cycles.
- Double buffer: mid-frame, load 32'hFFFFFFFF → the remaining digits of that frame still show the old value. From the frame_start cycle onward, every digit shows F (0001110).
- Coincident load/wrap plus back-to-back loads: load 32'h11111111 then 32'h22222222 in the same frame → the next frame shows only 2. A load of 32'hAAAAAAAA on the wrap cycle → that frame shows A immediately.
- digit_en=8'b0000_0101: only anode=FE and FB ever go low, while frame timing is unchanged at 64 cycles.
